// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter: shares one registered AXI4-Stream output between N_SRC
// sources, locks the grant per packet, tags beats with the source id and reports packet bytes.
module stream_packet_arbiter #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned WIDTH = 512,
   parameter int unsigned CNT_W = 32,
   localparam int unsigned BYTES = WIDTH / 8,
   localparam int unsigned ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [N_SRC*WIDTH-1:0]   i_tdata,
   input  logic [N_SRC*BYTES-1:0]   i_tkeep,
   input  logic [N_SRC-1:0]         i_tlast,
   input  logic [N_SRC-1:0]         i_tvalid,
   output logic [N_SRC-1:0]         i_tready,
   output logic [WIDTH-1:0]         o_tdata,
   output logic [BYTES-1:0]         o_tkeep,
   output logic                     o_tlast,
   output logic [ID_W-1:0]          o_tid,
   output logic                     o_tvalid,
   input  logic                     o_tready,
   output logic                     o_done,
   output logic [ID_W-1:0]          o_done_id,
   output logic [CNT_W-1:0]         o_done_bytes
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StBusy = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             adv;
   logic             accept;
   logic             any_valid;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  rr_next;
   logic [WIDTH-1:0] sel_tdata;
   logic [BYTES-1:0] sel_tkeep;
   logic             sel_tlast;
   logic             sel_tvalid;
   logic [CNT_W-1:0] beat_bytes;
   logic [CNT_W-1:0] count_sum;

   // Output stage can take a new beat when empty or draining this cycle.
   assign adv        = !o_tvalid || o_tready;
   assign sel_tdata  = i_tdata[grant_q*WIDTH +: WIDTH];
   assign sel_tkeep  = i_tkeep[grant_q*BYTES +: BYTES];
   assign sel_tlast  = i_tlast[grant_q];
   assign sel_tvalid = i_tvalid[grant_q];
   assign accept     = (state_q == StBusy) && adv && sel_tvalid;
   assign beat_bytes = CNT_W'($countones(sel_tkeep));
   assign count_sum  = count_q + beat_bytes;
   assign rr_next    = (32'(grant_q) == N_SRC - 1) ? '0 : grant_q + 1'b1;

   // First requester at or after rr_ptr, wrapping modulo N_SRC.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      winner    = '0;
      any_valid = 1'b0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         idx = (32'(rr_ptr_q) + k) % N_SRC;
         if (!any_valid && i_tvalid[idx]) begin
            any_valid = 1'b1;
            winner    = ID_W'(idx);
         end
      end
   end

   always_comb begin
      i_tready = '0;
      if (state_q == StBusy) begin
         i_tready[grant_q] = adv;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      count_d  = count_q;
      case (state_q)
         StIdle: begin
            if (any_valid) begin
               grant_d = winner;
               count_d = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (accept) begin
               count_d = count_sum;
               if (sel_tlast) begin
                  rr_ptr_d = rr_next;
                  state_d  = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         count_q      <= '0;
         o_tvalid     <= 1'b0;
         o_tlast      <= 1'b0;
         o_tid        <= '0;
         o_done       <= 1'b0;
         o_done_id    <= '0;
         o_done_bytes <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         o_done   <= accept && sel_tlast;
         if (accept) begin
            o_tvalid <= 1'b1;
            o_tlast  <= sel_tlast;
            o_tid    <= grant_q;
         end else if (o_tready) begin
            o_tvalid <= 1'b0;
         end
         if (accept && sel_tlast) begin
            o_done_id    <= grant_q;
            o_done_bytes <= count_sum;
         end
      end
   end

   // Payload carries no reset; it is qualified by o_tvalid.
   always_ff @(posedge aclk) begin
      if (accept) begin
         o_tdata <= sel_tdata;
         o_tkeep <= sel_tkeep;
      end
   end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Self-checking bench for stream_packet_arbiter: scoreboarded beats and packet completions,
// table-driven packets, plus hand-written round-robin, lock, stall and reset sequences.
module tb_stream_packet_arbiter;

   localparam int unsigned N_SRC = 4;
   localparam int unsigned WIDTH = 512;
   localparam int unsigned CNT_W = 32;
   localparam int unsigned BYTES = WIDTH / 8;
   localparam int unsigned ID_W  = 2;

   localparam logic [BYTES-1:0] KeepAll  = '1;
   localparam logic [BYTES-1:0] KeepNone = '0;
   localparam logic [BYTES-1:0] Keep0F   = {{(BYTES-4){1'b0}}, 4'hF};
   localparam logic [BYTES-1:0] Keep01   = {{(BYTES-1){1'b0}}, 1'b1};
   localparam logic [BYTES-1:0] Keep03   = {{(BYTES-2){1'b0}}, 2'h3};
   localparam logic [BYTES-1:0] KeepFF   = {{(BYTES-8){1'b0}}, 8'hFF};

   logic                   aclk = 1'b0;
   logic                   aresetn = 1'b0;
   logic [N_SRC*WIDTH-1:0] i_tdata;
   logic [N_SRC*BYTES-1:0] i_tkeep;
   logic [N_SRC-1:0]       i_tlast;
   logic [N_SRC-1:0]       i_tvalid;
   logic [N_SRC-1:0]       i_tready;
   logic [WIDTH-1:0]       o_tdata;
   logic [BYTES-1:0]       o_tkeep;
   logic                   o_tlast;
   logic [ID_W-1:0]        o_tid;
   logic                   o_tvalid;
   logic                   o_tready;
   logic                   o_done;
   logic [ID_W-1:0]        o_done_id;
   logic [CNT_W-1:0]       o_done_bytes;

   logic [WIDTH-1:0] src_data [N_SRC];
   logic [BYTES-1:0] src_keep [N_SRC];
   logic             src_last [N_SRC];
   logic             src_vld  [N_SRC];

   always_comb begin
      for (int s = 0; s < N_SRC; s++) begin
         i_tdata[s*WIDTH +: WIDTH] = src_data[s];
         i_tkeep[s*BYTES +: BYTES] = src_keep[s];
         i_tlast[s]                = src_last[s];
         i_tvalid[s]               = src_vld[s];
      end
   end

   stream_packet_arbiter #(
      .N_SRC (N_SRC),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .i_tdata      (i_tdata),
      .i_tkeep      (i_tkeep),
      .i_tlast      (i_tlast),
      .i_tvalid     (i_tvalid),
      .i_tready     (i_tready),
      .o_tdata      (o_tdata),
      .o_tkeep      (o_tkeep),
      .o_tlast      (o_tlast),
      .o_tid        (o_tid),
      .o_tvalid     (o_tvalid),
      .o_tready     (o_tready),
      .o_done       (o_done),
      .o_done_id    (o_done_id),
      .o_done_bytes (o_done_bytes)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [BYTES-1:0] keep;
      logic             last;
      int               id;
   } beat_t;

   typedef struct {
      int               id;
      logic [CNT_W-1:0] bytes;
   } done_t;

   typedef struct {
      int                      src;
      int                      nbeats;
      logic [3:0][BYTES-1:0]   kp;
      int                      rmode;
      logic [CNT_W-1:0]        exp_bytes;
   } vec_t;

   beat_t            beat_q[$];
   done_t            done_q[$];
   int               done_log_id[$];
   int               done_log_cyc[$];
   logic [CNT_W-1:0] acc [N_SRC];
   int               lock_src;
   int               rdy_mode;
   int               checks;
   int               errors;
   int               cyc;
   logic             stop;
   vec_t             vecs [4];

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   // Pushes expectations on every input handshake, pops them as the DUT emits output.
   task automatic monitor();
      beat_t            b;
      done_t            d;
      logic [WIDTH-1:0] hold_data;
      logic [BYTES-1:0] hold_keep;
      logic             hold_last;
      logic [ID_W-1:0]  hold_tid;
      logic             stalled;
      stalled = 1'b0;
      forever begin
         @(negedge aclk);
         cyc++;
         if (!aresetn) begin
            beat_q.delete();
            done_q.delete();
            for (int s = 0; s < N_SRC; s++) acc[s] = '0;
            lock_src = -1;
            stalled  = 1'b0;
         end else begin
            chk("ready_at_most_one", WIDTH'($countones(i_tready) <= 1), 1);
            if (stalled) begin
               chk("stall_valid", o_tvalid, 1);
               chk("stall_data", o_tdata, hold_data);
               chk("stall_keep", o_tkeep, hold_keep);
               chk("stall_last", o_tlast, hold_last);
               chk("stall_tid", o_tid, hold_tid);
            end
            if (o_tvalid && o_tready) begin
               if (beat_q.size() == 0) begin
                  chk("unexpected_beat", beat_q.size(), 1);
               end else begin
                  b = beat_q.pop_front();
                  chk("beat_data", o_tdata, b.data);
                  chk("beat_keep", o_tkeep, b.keep);
                  chk("beat_last", o_tlast, b.last);
                  chk("beat_tid", o_tid, b.id);
               end
            end
            if (o_done) begin
               done_log_id.push_back(int'(o_done_id));
               done_log_cyc.push_back(cyc);
               chk("done_with_last_beat", o_tvalid && o_tlast, 1);
               if (done_q.size() == 0) begin
                  chk("unexpected_done", done_q.size(), 1);
               end else begin
                  d = done_q.pop_front();
                  chk("done_id", o_done_id, d.id);
                  chk("done_bytes", o_done_bytes, d.bytes);
               end
            end
            for (int s = 0; s < N_SRC; s++) begin
               if (src_vld[s] && i_tready[s]) begin
                  if (lock_src >= 0) chk("no_interleave", s, lock_src);
                  b.data = src_data[s];
                  b.keep = src_keep[s];
                  b.last = src_last[s];
                  b.id   = s;
                  beat_q.push_back(b);
                  acc[s] = acc[s] + CNT_W'($countones(src_keep[s]));
                  if (src_last[s]) begin
                     d.id    = s;
                     d.bytes = acc[s];
                     done_q.push_back(d);
                     acc[s]   = '0;
                     lock_src = -1;
                  end else begin
                     lock_src = s;
                  end
               end
            end
            stalled   = o_tvalid && !o_tready;
            hold_data = o_tdata;
            hold_keep = o_tkeep;
            hold_last = o_tlast;
            hold_tid  = o_tid;
         end
      end
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            0:       o_tready = 1'b1;
            1:       o_tready = ~o_tready;
            default: o_tready = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   // Call at posedge+1; returns at posedge+1 after the last beat is accepted.
   task automatic send_pkt(input int s, input int nbeats, input logic [3:0][BYTES-1:0] kp,
                           input int gap_at, input int gap_len);
      int waited;
      for (int b = 0; b < nbeats; b++) begin
         if (b == gap_at) begin
            src_vld[s] = 1'b0;
            repeat (gap_len) @(posedge aclk);
            #1;
         end
         src_data[s] = rand_word();
         src_keep[s] = kp[b % 4];
         src_last[s] = (b == nbeats - 1);
         src_vld[s]  = 1'b1;
         waited = 0;
         do begin
            @(negedge aclk);
            waited++;
         end while (!i_tready[s] && waited < 200);
         chk("src_handshake", i_tready[s], 1);
         if (!i_tready[s]) begin
            src_vld[s] = 1'b0;
            return;
         end
         @(posedge aclk);
         #1;
      end
      src_vld[s]  = 1'b0;
      src_last[s] = 1'b0;
   endtask

   task automatic src_loop(input int s);
      while (!stop) send_pkt(s, 1, {KeepAll, KeepAll, KeepAll, KeepAll}, -1, 0);
   endtask

   task automatic wait_done(output int id, output logic [CNT_W-1:0] bytes);
      int n;
      n     = 0;
      id    = -1;
      bytes = '0;
      while (n < 20) begin
         @(negedge aclk);
         n++;
         if (o_done) begin
            id    = int'(o_done_id);
            bytes = o_done_bytes;
            break;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   initial begin
      int               got_id;
      logic [CNT_W-1:0] got_bytes;
      int               per_src [N_SRC];
      int               waited;

      checks   = 0;
      errors   = 0;
      cyc      = 0;
      lock_src = -1;
      rdy_mode = 0;
      stop     = 1'b0;
      o_tready = 1'b1;
      for (int s = 0; s < N_SRC; s++) begin
         src_data[s] = '0;
         src_keep[s] = '0;
         src_last[s] = 1'b0;
         src_vld[s]  = 1'b0;
         acc[s]      = '0;
      end

      vecs[0].src = 2; vecs[0].nbeats = 3; vecs[0].rmode = 0;
      vecs[0].kp  = {KeepAll, KeepAll, KeepAll, KeepAll};
      vecs[0].exp_bytes = CNT_W'(3 * BYTES);
      vecs[1].src = 1; vecs[1].nbeats = 4; vecs[1].rmode = 1;
      vecs[1].kp  = {Keep01, KeepAll, KeepNone, Keep0F};
      vecs[1].exp_bytes = CNT_W'(4 + 0 + BYTES + 1);
      vecs[2].src = 0; vecs[2].nbeats = 1; vecs[2].rmode = 0;
      vecs[2].kp  = {KeepNone, KeepNone, KeepNone, KeepNone};
      vecs[2].exp_bytes = CNT_W'(0);
      vecs[3].src = 3; vecs[3].nbeats = 2; vecs[3].rmode = 2;
      vecs[3].kp  = {KeepAll, KeepAll, Keep03, KeepFF};
      vecs[3].exp_bytes = CNT_W'(8 + 2);

      fork
         monitor();
         ready_drv();
      join_none

      // Reset and idle: nothing granted, nothing emitted.
      idle_cycles(3);
      aresetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         chk("idle_tready", i_tready, 0);
         chk("idle_tvalid", o_tvalid, 0);
         chk("idle_done", o_done, 0);
      end
      chk("reset_tid", o_tid, 0);
      chk("reset_tlast", o_tlast, 0);
      chk("reset_done_id", o_done_id, 0);
      chk("reset_done_bytes", o_done_bytes, 0);
      idle_cycles(1);

      // All sources request continuously with single-beat packets.
      done_log_id.delete();
      done_log_cyc.delete();
      fork
         src_loop(0);
         src_loop(1);
         src_loop(2);
         src_loop(3);
         begin
            repeat (40) @(posedge aclk);
            stop = 1'b1;
         end
      join
      idle_cycles(6);
      chk("rr_enough_dones", WIDTH'(done_log_id.size() >= 20), 1);
      for (int s = 0; s < N_SRC; s++) per_src[s] = 0;
      for (int i = 0; i < 20 && i < done_log_id.size(); i++) begin
         chk("rr_order", done_log_id[i], i % 4);
         if (i > 0) chk("rr_idle_gap", done_log_cyc[i] - done_log_cyc[i-1], 2);
         per_src[done_log_id[i] % N_SRC]++;
      end
      for (int s = 0; s < N_SRC; s++) chk("rr_fair_count", per_src[s], 5);

      // Table-driven single packets with varied keep and output back-pressure.
      for (int v = 0; v < 4; v++) begin
         rdy_mode = vecs[v].rmode;
         send_pkt(vecs[v].src, vecs[v].nbeats, vecs[v].kp, -1, 0);
         wait_done(got_id, got_bytes);
         chk("tbl_done_id", got_id, vecs[v].src);
         chk("tbl_done_bytes", got_bytes, vecs[v].exp_bytes);
         rdy_mode = 0;
         idle_cycles(4);
      end

      // Source 1 pauses mid-packet; source 0 must wait for its tlast.
      done_log_id.delete();
      fork
         send_pkt(1, 4, {KeepAll, KeepAll, KeepAll, KeepAll}, 2, 5);
         begin
            idle_cycles(2);
            send_pkt(0, 2, {Keep0F, Keep0F, Keep0F, Keep0F}, -1, 0);
         end
      join
      idle_cycles(6);
      chk("lock_done_count", done_log_id.size(), 2);
      if (done_log_id.size() == 2) begin
         chk("lock_first", done_log_id[0], 1);
         chk("lock_second", done_log_id[1], 0);
      end

      // Source 2 completes so the pointer moves to 3, then reset hits a source-3 packet.
      send_pkt(2, 1, {KeepAll, KeepAll, KeepAll, KeepAll}, -1, 0);
      idle_cycles(4);
      src_data[3] = rand_word();
      src_keep[3] = KeepAll;
      src_last[3] = 1'b0;
      src_vld[3]  = 1'b1;
      waited = 0;
      do begin
         @(negedge aclk);
         waited++;
      end while (!i_tready[3] && waited < 50);
      chk("partial_grant", i_tready[3], 1);
      idle_cycles(1);
      src_data[3] = rand_word();
      idle_cycles(1);
      aresetn   = 1'b0;
      src_vld[3] = 1'b0;
      idle_cycles(1);
      aresetn = 1'b1;
      chk("rst_tvalid", o_tvalid, 0);
      chk("rst_done", o_done, 0);
      chk("rst_tready", i_tready, 0);

      // Pointer back at 0: source 0 beats source 3.
      done_log_id.delete();
      fork
         send_pkt(3, 1, {KeepFF, KeepFF, KeepFF, KeepFF}, -1, 0);
         send_pkt(0, 1, {Keep01, Keep01, Keep01, Keep01}, -1, 0);
      join
      idle_cycles(6);
      chk("post_rst_count", done_log_id.size(), 2);
      if (done_log_id.size() == 2) begin
         chk("post_rst_first", done_log_id[0], 0);
         chk("post_rst_second", done_log_id[1], 3);
      end
      send_pkt(3, 3, {KeepAll, KeepAll, KeepAll, KeepAll}, -1, 0);
      wait_done(got_id, got_bytes);
      chk("fresh_done_id", got_id, 3);
      chk("fresh_done_bytes", got_bytes, CNT_W'(3 * BYTES));
      idle_cycles(6);

      chk("sb_beats_drained", beat_q.size(), 0);
      chk("sb_dones_drained", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
